// File: rtl/uart_pkt_ctrl_pkg.sv
// uart_pkt_ctrl_pkg: shared frame constant and FSM state encodings for the packet controller
// Contents: SYNC_DEF (default frame start byte), tx_state_t, rx_state_t
package uart_pkt_ctrl_pkg;
  localparam logic [7:0] SYNC_DEF = 8'hA5;
  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_CSUM} tx_state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_DATA, RX_CHK} rx_state_t;
endpackage

// File: rtl/uart_pkt_ctrl_rr_arb2.sv
// uart_pkt_ctrl_rr_arb2: 2-way round-robin arbiter with a last-grant pointer
// Ports: clk, reset (async, active-high), req[1:0] requests, en (grant is taken this
//        edge), gnt[1:0] combinational one-hot grant
module uart_pkt_ctrl_rr_arb2
  import uart_pkt_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;
  // last=1 means requester 1 was served most recently, so requester 0 wins a tie
  always_comb gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (en && |req) last <= gnt[1];
endmodule

// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl: packet framing (SYNC, payload, XOR checksum) over a FIFO-buffered UART
// Ports: clk, reset (async, active-high)
//        req0/req1, pay0/pay1 in; ack0/ack1, tx_busy, tx_done out   - TX requesters
//        wr_uart, w_data out; tx_full in                            - UART TX FIFO
//        rd_uart out; r_data, rx_empty in                           - UART RX FIFO (FWFT)
//        rx_payload, rx_valid, rx_err out                           - received packets
module uart_pkt_ctrl
  import uart_pkt_ctrl_pkg::*;
#(
  parameter int         PLEN  = 2,
  parameter logic [7:0] SYNC  = SYNC_DEF,
  parameter int         CNT_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [PLEN*8-1:0] pay0,
  input  logic [PLEN*8-1:0] pay1,
  output logic              ack0,
  output logic              ack1,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  input  logic              tx_full,
  output logic              rd_uart,
  input  logic [7:0]        r_data,
  input  logic              rx_empty,
  output logic [PLEN*8-1:0] rx_payload,
  output logic              rx_valid,
  output logic              rx_err
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PLEN - 1);
  tx_state_t         tx_st;
  rx_state_t         rx_st;
  logic [CNT_W-1:0]  tx_idx, rx_idx;
  logic [PLEN*8-1:0] tx_buf, rx_buf;
  logic [7:0]        tx_cs, rx_cs, tx_byte;
  logic [1:0]        gnt;
  logic              start;
  uart_pkt_ctrl_rr_arb2 u_arb (
    .clk  (clk),
    .reset(reset),
    .req  ({req1, req0}),
    .en   (start),
    .gnt  (gnt)
  );
  always_comb begin
    tx_byte = tx_buf[{tx_idx, 3'b000} +: 8];
    tx_busy = tx_st != TX_IDLE;
    wr_uart = tx_busy && !tx_full;
    w_data  = tx_st == TX_SYNC ? SYNC : tx_st == TX_DATA ? tx_byte : tx_st == TX_CSUM ? tx_cs : 8'h00;
    // a pending request is granted from IDLE or on the edge that writes the checksum
    start   = (req0 || req1) && (tx_st == TX_IDLE || (tx_st == TX_CSUM && wr_uart));
    rd_uart = !rx_empty && !reset;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_st   <= TX_IDLE;
      tx_idx  <= '0;
      tx_buf  <= '0;
      tx_cs   <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      ack0    <= start && gnt[0];
      ack1    <= start && gnt[1];
      tx_done <= tx_st == TX_CSUM && wr_uart;
      if (start) begin
        tx_st  <= TX_SYNC;
        tx_buf <= gnt[1] ? pay1 : pay0;
        tx_cs  <= '0;
        tx_idx <= '0;
      end else if (wr_uart) begin
        if (tx_st == TX_SYNC) tx_st <= TX_DATA;
        else if (tx_st == TX_DATA) begin
          tx_cs  <= tx_cs ^ tx_byte;
          tx_idx <= tx_idx + CNT_W'(1);
          if (tx_idx == LAST) tx_st <= TX_CSUM;
        end else tx_st <= TX_IDLE;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_st      <= RX_HUNT;
      rx_idx     <= '0;
      rx_buf     <= '0;
      rx_cs      <= '0;
      rx_payload <= '0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_valid <= rd_uart && rx_st == RX_CHK && r_data == rx_cs;
      rx_err   <= rd_uart && rx_st == RX_CHK && r_data != rx_cs;
      if (rd_uart) begin
        if (rx_st == RX_HUNT) begin
          if (r_data == SYNC) begin
            rx_st  <= RX_DATA;
            rx_idx <= '0;
            rx_cs  <= '0;
          end
        end else if (rx_st == RX_DATA) begin
          rx_buf[{rx_idx, 3'b000} +: 8] <= r_data;
          rx_cs  <= rx_cs ^ r_data;
          rx_idx <= rx_idx + CNT_W'(1);
          if (rx_idx == LAST) rx_st <= RX_CHK;
        end else begin
          if (r_data == rx_cs) rx_payload <= rx_buf;
          rx_st <= RX_HUNT;
        end
      end
    end
endmodule
